// File: rtl/seq_div.sv
// Sequential signed restoring divider: 20-bit dividend by 8-bit divisor,
// one shift-subtract step per clock, then one sign-fix/saturate cycle.
module seq_div #(
    parameter int QBITS = 12,
    parameter int DBITS = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [QBITS+DBITS-1:0] dvd,
    input  logic [DBITS-1:0]       dvs,
    input  logic                   start,
    output logic [QBITS-1:0]       quot,
    output logic [DBITS-1:0]       rem,
    output logic                   busy,
    output logic                   ovf,
    output logic                   dz
);

    localparam int N  = QBITS + DBITS;
    localparam int CW = $clog2(N);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX
    } state_t;

    localparam logic [QBITS-1:0] QMAX = {1'b0, {(QBITS-1){1'b1}}};
    localparam logic [QBITS-1:0] QMIN = {1'b1, {(QBITS-1){1'b0}}};

    state_t           state_q, state_d;
    logic [N-1:0]     q_q, q_d;
    logic [DBITS:0]   r_q, r_d;
    logic [DBITS-1:0] dvs_q, dvs_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             sgnq_q, sgnq_d;
    logic             sgnr_q, sgnr_d;
    logic             zero_q, zero_d;
    logic [QBITS-1:0] quot_q, quot_d;
    logic [DBITS-1:0] rem_q, rem_d;
    logic             busy_q, busy_d;
    logic             ovf_q, ovf_d;
    logic             dz_q, dz_d;

    logic [DBITS:0]   r_sh;
    logic [N-1:0]     q_sh;
    logic [N-1:0]     lim;
    logic             too_big;

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        r_d     = r_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        sgnq_d  = sgnq_q;
        sgnr_d  = sgnr_q;
        zero_d  = zero_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        busy_d  = busy_q;
        ovf_d   = ovf_q;
        dz_d    = dz_q;
        r_sh    = {r_q[DBITS-1:0], q_q[N-1]};
        q_sh    = {q_q[N-2:0], 1'b0};
        // Negative results may reach one further than positive ones.
        lim     = N'((1 << (QBITS - 1)) - 1) + N'(sgnq_q);
        too_big = q_q > lim;

        case (state_q)
            IDLE: begin
                if (start) begin
                    q_d     = dvd[N-1] ? -dvd : dvd;
                    dvs_d   = dvs[DBITS-1] ? -dvs : dvs;
                    r_d     = '0;
                    cnt_d   = '0;
                    sgnq_d  = dvd[N-1] ^ dvs[DBITS-1];
                    sgnr_d  = dvd[N-1];
                    zero_d  = (dvs == '0);
                    ovf_d   = 1'b0;
                    dz_d    = 1'b0;
                    busy_d  = 1'b1;
                    state_d = (dvs == '0) ? FIX : CALC;
                end
            end
            CALC: begin
                if (r_sh >= {1'b0, dvs_q}) begin
                    r_sh    = r_sh - {1'b0, dvs_q};
                    q_sh[0] = 1'b1;
                end
                r_d   = r_sh;
                q_d   = q_sh;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(N - 1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                busy_d  = 1'b0;
                state_d = IDLE;
                if (zero_q) begin
                    quot_d = '0;
                    rem_d  = '0;
                    dz_d   = 1'b1;
                    ovf_d  = 1'b0;
                end else begin
                    ovf_d = too_big;
                    if (too_big) begin
                        quot_d = sgnq_q ? QMIN : QMAX;
                    end else begin
                        quot_d = sgnq_q ? -q_q[QBITS-1:0]
                                        : q_q[QBITS-1:0];
                    end
                    rem_d = sgnr_q ? -r_q[DBITS-1:0] : r_q[DBITS-1:0];
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            q_q     <= '0;
            r_q     <= '0;
            dvs_q   <= '0;
            cnt_q   <= '0;
            sgnq_q  <= 1'b0;
            sgnr_q  <= 1'b0;
            zero_q  <= 1'b0;
            quot_q  <= '0;
            rem_q   <= '0;
            busy_q  <= 1'b0;
            ovf_q   <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            r_q     <= r_d;
            dvs_q   <= dvs_d;
            cnt_q   <= cnt_d;
            sgnq_q  <= sgnq_d;
            sgnr_q  <= sgnr_d;
            zero_q  <= zero_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            busy_q  <= busy_d;
            ovf_q   <= ovf_d;
            dz_q    <= dz_d;
        end
    end

    assign quot = quot_q;
    assign rem  = rem_q;
    assign busy = busy_q;
    assign ovf  = ovf_q;
    assign dz   = dz_q;

endmodule

// File: tb/tb_seq_div.sv
// Self-checking bench for seq_div: directed cases, disturbances,
// a product sweep and random operands against an arithmetic model.
module tb_seq_div;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [19:0] dvd = '0;
    logic [7:0]  dvs = '0;
    logic        start = 1'b0;
    logic [11:0] quot;
    logic [7:0]  rem;
    logic        busy;
    logic        ovf;
    logic        dz;

    int errors = 0;
    int checks = 0;

    seq_div #(.QBITS(12), .DBITS(8)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .dvd  (dvd),
        .dvs  (dvs),
        .start(start),
        .quot (quot),
        .rem  (rem),
        .busy (busy),
        .ovf  (ovf),
        .dz   (dz)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Truncating division; remainder takes the dividend's sign.
    task automatic model(input int a, input int b,
                         output int q, output int r,
                         output int o, output int z);
        if (b == 0) begin
            q = 0; r = 0; o = 0; z = 1;
        end else begin
            q = a / b;
            r = a % b;
            z = 0;
            o = (q > 2047 || q < -2048) ? 1 : 0;
            if (o != 0) q = (q > 0) ? 2047 : -2048;
        end
    endtask

    task automatic run(input int a, input int b, input int poke,
                       output int cyc);
        dvd   = 20'(a);
        dvs   = 8'(b);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        dvd   = 20'($urandom);
        dvs   = 8'($urandom);
        cyc   = 0;
        while (busy === 1'b1 && cyc < 100) begin
            cyc++;
            if (poke != 0 && cyc == poke) start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
    endtask

    task automatic div_chk(input string tag, input int a, input int b,
                           input int poke);
        int q, r, o, z, cyc;
        model(a, b, q, r, o, z);
        run(a, b, poke, cyc);
        chk({tag, " quot"}, int'($signed(quot)), q);
        chk({tag, " rem"}, int'($signed(rem)), r);
        chk({tag, " ovf"}, int'(ovf), o);
        chk({tag, " dz"}, int'(dz), z);
        chk({tag, " busy_cycles"}, cyc, (z != 0) ? 1 : 21);
    endtask

    task automatic zero_chk(input string tag);
        chk({tag, " busy"}, int'(busy), 0);
        chk({tag, " quot"}, int'(quot), 0);
        chk({tag, " rem"}, int'(rem), 0);
        chk({tag, " ovf"}, int'(ovf), 0);
        chk({tag, " dz"}, int'(dz), 0);
    endtask

    initial begin
        logic signed [19:0] rv;
        logic signed [7:0]  rb;
        int a;
        int b;

        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        zero_chk("reset");
        rst_n = 1'b1;
        @(negedge clk);

        div_chk("60/-7", 60, -7, 0);
        div_chk("-60/7", -60, 7, 0);
        div_chk("-21/-7", -21, -7, 0);
        div_chk("2048/1", 2048, 1, 0);
        div_chk("2048/-1", 2048, -1, 0);
        div_chk("-524288/-1", -524288, -1, 0);
        div_chk("123/0", 123, 0, 0);
        div_chk("10/3", 10, 3, 0);
        div_chk("524287/-128", 524287, -128, 0);
        div_chk("-524288/-128", -524288, -128, 0);
        div_chk("-3/7", -3, 7, 0);
        div_chk("poke", 1000, -9, 5);

        dvd   = 20'(5000);
        dvs   = 8'(37);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        chk("mid_rst busy_before", int'(busy), 1);
        rst_n = 1'b0;
        @(negedge clk);
        zero_chk("mid_rst");
        rst_n = 1'b1;
        div_chk("after_rst", 5000, 37, 0);

        for (int k = -8; k <= 8; k++) begin
            for (int j = -7; j <= 7; j++) begin
                if (j != 0) div_chk("sweep", k * j, j, 0);
            end
        end

        for (int i = 0; i < 150; i++) begin
            rv = 20'($urandom);
            rb = 8'($urandom);
            case ($urandom_range(0, 2))
                0: a = int'(rv);
                1: a = int'($urandom_range(0, 60000)) - 30000;
                default: a = int'($urandom_range(0, 4000)) - 2000;
            endcase
            b = int'(rb);
            div_chk("random", a, b, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
